// File: rtl/mul_div_unit.sv
// Iterative 16x16 unsigned multiply / restoring divide with register-file write-back.
// Define MULDIV_DIV_EN to build the divider; without it, Op=1x finishes at once with no write.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [15:0] Operand_A,
  input  logic [15:0] Operand_B,
  input  logic [3:0]  Dest_Reg,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Result,
  output logic [3:0]  Write_Reg,
  output logic        RegWrite,
  output logic        Div_By_Zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] a_q;
  logic [1:0]  op_q;
  logic [3:0]  dest_q;
  logic [3:0]  cnt;
  logic [31:0] acc;
  logic [31:0] acc_nxt;
  logic [16:0] mul_sum;
  logic [31:0] mul_nxt;
  logic        early_exit;
  logic [15:0] res_nxt;
  logic        wr_nxt;
  logic        dbz_nxt;

`ifdef MULDIV_DIV_EN
  logic [15:0] b_q;
  logic [16:0] div_sh;
  logic [15:0] div_diff;
  logic        div_ge;
  logic [31:0] div_nxt;
`endif

  // MUL: acc = {partial product, remaining multiplier bits}, shifted right each step.
  always_comb begin
    mul_sum = {1'b0, acc[31:16]} + (acc[0] ? {1'b0, a_q} : 17'd0);
    mul_nxt = {mul_sum, acc[15:1]};
  end

`ifdef MULDIV_DIV_EN
  // DIV: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
  // The partial remainder stays below b_q, so a 16-bit difference is exact.
  always_comb begin
    div_sh   = {acc[31:16], acc[15]};
    div_ge   = div_sh >= {1'b0, b_q};
    div_diff = div_sh[15:0] - b_q;
    div_nxt  = div_ge ? {div_diff, acc[14:0], 1'b1}
                      : {div_sh[15:0], acc[14:0], 1'b0};
  end

  always_comb begin
    acc_nxt    = op_q[1] ? div_nxt : mul_nxt;
    early_exit = op_q[1] && (b_q == 16'd0);
    wr_nxt     = 1'b1;
    dbz_nxt    = early_exit;
    unique case (op_q)
      2'b00:   res_nxt = mul_nxt[15:0];
      2'b01:   res_nxt = mul_nxt[31:16];
      2'b10:   res_nxt = (b_q == 16'd0) ? 16'hFFFF : div_nxt[15:0];
      default: res_nxt = (b_q == 16'd0) ? a_q     : div_nxt[31:16];
    endcase
  end
`else
  always_comb begin
    acc_nxt    = mul_nxt;
    early_exit = op_q[1];
    wr_nxt     = !op_q[1];
    dbz_nxt    = 1'b0;
    unique case (op_q)
      2'b00:   res_nxt = mul_nxt[15:0];
      2'b01:   res_nxt = mul_nxt[31:16];
      default: res_nxt = 16'd0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (early_exit || cnt == 4'd15) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      op_q        <= '0;
      dest_q      <= '0;
      cnt         <= '0;
      acc         <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      RegWrite    <= 1'b0;
      Div_By_Zero <= 1'b0;
      Result      <= '0;
      Write_Reg   <= '0;
`ifdef MULDIV_DIV_EN
      b_q         <= '0;
`endif
    end else begin
      Busy        <= (state_nxt != IDLE);
      Done        <= (state_nxt == DONE);
      RegWrite    <= (state_nxt == DONE) && wr_nxt;
      Div_By_Zero <= (state_nxt == DONE) && dbz_nxt;
      unique case (state)
        IDLE: if (Start) begin
          a_q    <= Operand_A;
          op_q   <= Op;
          dest_q <= Dest_Reg;
          cnt    <= '0;
`ifdef MULDIV_DIV_EN
          b_q    <= Operand_B;
          acc    <= {16'd0, Op[1] ? Operand_A : Operand_B};
`else
          acc    <= {16'd0, Operand_B};
`endif
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 4'd1;
          if (state_nxt == DONE) begin
            Result    <= res_nxt;
            Write_Reg <= dest_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus reset-abort, ignored-Start and back-to-back sequences.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [15:0] Operand_A = '0;
  logic [15:0] Operand_B = '0;
  logic [3:0]  Dest_Reg = '0;
  logic        Busy, Done, RegWrite, Div_By_Zero;
  logic [15:0] Result;
  logic [3:0]  Write_Reg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk(clk), .rst(rst), .Start(Start), .Op(Op),
    .Operand_A(Operand_A), .Operand_B(Operand_B), .Dest_Reg(Dest_Reg),
    .Busy(Busy), .Done(Done), .Result(Result), .Write_Reg(Write_Reg),
    .RegWrite(RegWrite), .Div_By_Zero(Div_By_Zero)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [3:0]  dest;
    logic [15:0] res;
    logic        rw, dbz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [3:0] d, input logic [15:0] r, input logic rw, input logic dbz, input int lat);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.dest = d;
    v.res = r; v.rw = rw; v.dbz = dbz; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    logic busy_ok, early_done;
    busy_ok = 1'b1;
    early_done = 1'b0;
    Op = v.op; Operand_A = v.a; Operand_B = v.b; Dest_Reg = v.dest; Start = 1'b1;
    tick();  // E0
    Start = 1'b0;
    if (Busy !== 1'b1) busy_ok = 1'b0;
    for (int c = 1; c <= v.lat; c++) begin
      tick();
      if (Busy !== 1'b1) busy_ok = 1'b0;
      if (c < v.lat && (Done !== 1'b0 || RegWrite !== 1'b0)) early_done = 1'b1;
    end
    chk({v.name, " busy"}, busy_ok, 1'b1);
    chk({v.name, " early_done"}, early_done, 1'b0);
    chk({v.name, " done"}, Done, 1'b1);
    chk({v.name, " result"}, Result, v.res);
    chk({v.name, " write_reg"}, Write_Reg, v.dest);
    chk({v.name, " regwrite"}, RegWrite, v.rw);
    chk({v.name, " dbz"}, Div_By_Zero, v.dbz);
    tick();
    chk({v.name, " idle"}, {Busy, Done, RegWrite, Div_By_Zero}, 4'b0000);
    tick();
  endtask

  initial begin
    add("mul_lo_1234", 2'b00, 16'h1234, 16'h0010, 4'd3, 16'h2340, 1'b1, 1'b0, 16);
    add("mul_hi_1234", 2'b01, 16'h1234, 16'h0010, 4'd3, 16'h0001, 1'b1, 1'b0, 16);
    add("mul_hi_ffff", 2'b01, 16'hFFFF, 16'hFFFF, 4'd7, 16'hFFFE, 1'b1, 1'b0, 16);
    add("mul_lo_ffff", 2'b00, 16'hFFFF, 16'hFFFF, 4'd7, 16'h0001, 1'b1, 1'b0, 16);
    add("mul_lo_abcd", 2'b00, 16'hABCD, 16'h0003, 4'd0, 16'h0367, 1'b1, 1'b0, 16);
    add("mul_hi_abcd", 2'b01, 16'hABCD, 16'h0003, 4'd15, 16'h0002, 1'b1, 1'b0, 16);
    add("mul_hi_8000", 2'b01, 16'h8000, 16'h8000, 4'd9, 16'h4000, 1'b1, 1'b0, 16);
    add("mul_zero",    2'b00, 16'h0000, 16'hBEEF, 4'd1, 16'h0000, 1'b1, 1'b0, 16);
`ifdef MULDIV_DIV_EN
    add("div_q_100_7", 2'b10, 16'd100,  16'd7,    4'd4, 16'd14,   1'b1, 1'b0, 16);
    add("div_r_100_7", 2'b11, 16'd100,  16'd7,    4'd4, 16'd2,    1'b1, 1'b0, 16);
    add("div_q_ffff1", 2'b10, 16'hFFFF, 16'h0001, 4'd2, 16'hFFFF, 1'b1, 1'b0, 16);
    add("div_r_5_10",  2'b11, 16'd5,    16'd10,   4'd2, 16'd5,    1'b1, 1'b0, 16);
    add("div_q_5_10",  2'b10, 16'd5,    16'd10,   4'd0, 16'd0,    1'b1, 1'b0, 16);
    add("div_q_ffffs", 2'b10, 16'hFFFF, 16'hFFFF, 4'd6, 16'd1,    1'b1, 1'b0, 16);
    add("div_q_by0",   2'b10, 16'h0055, 16'h0000, 4'd8, 16'hFFFF, 1'b1, 1'b1, 1);
    add("div_r_by0",   2'b11, 16'h0055, 16'h0000, 4'd8, 16'h0055, 1'b1, 1'b1, 1);
`else
    add("nodiv_q",     2'b10, 16'd100,  16'd7,    4'd4, 16'd0,    1'b0, 1'b0, 1);
    add("nodiv_r",     2'b11, 16'd100,  16'd7,    4'd4, 16'd0,    1'b0, 1'b0, 1);
    add("nodiv_b0",    2'b10, 16'h0055, 16'h0000, 4'd4, 16'd0,    1'b0, 1'b0, 1);
`endif

    tick(); tick();
    chk("reset outputs", {Busy, Done, RegWrite, Div_By_Zero, Result, Write_Reg}, 24'd0);
    rst = 1'b0;
    tick();
    chk("idle after reset", {Busy, Done, RegWrite}, 3'b000);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a multiply aborts it with no write-back.
    begin
      logic wrote;
      wrote = 1'b0;
      Op = 2'b00; Operand_A = 16'h1234; Operand_B = 16'h0010; Dest_Reg = 4'd5; Start = 1'b1;
      tick();  // E0
      Start = 1'b0;
      for (int c = 1; c <= 8; c++) tick();
      chk("abort busy before rst", Busy, 1'b1);
      rst = 1'b1;
      tick();  // E9
      chk("abort busy", Busy, 1'b0);
      chk("abort result", {Done, RegWrite, Result, Write_Reg}, 22'd0);
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (RegWrite !== 1'b0 || Done !== 1'b0 || Busy !== 1'b0) wrote = 1'b1;
      end
      chk("abort no regwrite", wrote, 1'b0);
    end

    // A Start during RUN must not disturb the latched operands.
    Op = 2'b00; Operand_A = 16'd3; Operand_B = 16'd5; Dest_Reg = 4'd2; Start = 1'b1;
    tick();  // E0
    Start = 1'b0;
    for (int c = 1; c <= 3; c++) tick();
    Op = 2'b01; Operand_A = 16'd7; Operand_B = 16'd9; Dest_Reg = 4'd9; Start = 1'b1;
    tick();  // E4
    Start = 1'b0;
    for (int c = 5; c <= 16; c++) tick();
    chk("ignored start done", Done, 1'b1);
    chk("ignored start result", Result, 16'd15);
    chk("ignored start write_reg", Write_Reg, 4'd2);
    tick(); tick();

    // Start held high: DONE ignores it, IDLE at E17 accepts it at E18.
    Op = 2'b00; Operand_A = 16'd2; Operand_B = 16'd3; Dest_Reg = 4'd11; Start = 1'b1;
    tick();  // E0
    for (int c = 1; c <= 16; c++) tick();
    chk("b2b first done", {Done, Result}, {1'b1, 16'd6});
    tick();  // E17
    chk("b2b idle at E17", Busy, 1'b0);
    tick();  // E18
    Start = 1'b0;
    chk("b2b accept at E18", Busy, 1'b1);
    for (int c = 1; c <= 16; c++) tick();
    chk("b2b second done", {Done, RegWrite, Result, Write_Reg}, {1'b1, 1'b1, 16'd6, 4'd11});
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port Start, input, 1 bit: operation request, sampled only in IDLE.
REQ-004 SHALL have port Op, input, 2 bits: 00 MUL low half, 01 MUL high half, 10 DIV quotient, 11 DIV remainder; all unsigned.
REQ-005 SHALL have port Operand_A, input, 16 bits: multiplicand/dividend, driven from register-file Read_Data1.
REQ-006 SHALL have port Operand_B, input, 16 bits: multiplier/divisor, driven from register-file Read_Data2.
REQ-007 SHALL have port Dest_Reg, input, 4 bits: destination register index, latched with Start.
REQ-008 SHALL have port Busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 SHALL have port Done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port Result, output, 16 bits: write-back data to register-file Write_Data.
REQ-011 SHALL have port Write_Reg, output, 4 bits: write-back index to register-file Write_Reg.
REQ-012 SHALL have port RegWrite, output, 1 bit: write enable to register-file RegWrite.
REQ-013 SHALL have port Div_By_Zero, output, 1 bit: error flag, valid with Done.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-015 IDLE: Start=1 at an edge SHALL latch Operand_A, Operand_B, Op, Dest_Reg, clear the iteration counter, and go to RUN.
REQ-016 Start SHALL be ignored in RUN and DONE; latched operands SHALL NOT change until the next IDLE acceptance.
REQ-017 RUN SHALL execute exactly one iteration per cycle for 16 cycles: shift-add for MUL, restoring shift-subtract for DIV. After the 16th iteration edge, the FSM SHALL enter DONE.
REQ-018 Latency: with Start sampled at edge E0, Done, RegWrite and Result SHALL be valid between E16 and E17. The FSM SHALL return to IDLE at E17, and the earliest next accept SHALL be E18.
REQ-019 MUL SHALL form the full 32-bit product. Op=00 SHALL return bits [15:0] and Op=01 SHALL return bits [31:16].
REQ-020 DIV SHALL return the 16-bit quotient (Op=10) or the 16-bit remainder (Op=11).
REQ-021 DIV with latched Operand_B=0 SHALL skip RUN and enter DONE at E1. Result SHALL be 16'hFFFF for Op=10 and Operand_A for Op=11, with Div_By_Zero=1 and RegWrite=1.
REQ-022 In DONE, Write_Reg SHALL equal the latched Dest_Reg and RegWrite SHALL equal Done. Outside DONE, RegWrite, Done and Div_By_Zero SHALL be 0.
REQ-023 Result and Write_Reg SHALL hold stable for the whole DONE cycle so that the register file's falling-edge write captures them.
REQ-024 Dest_Reg=0 SHALL receive no special handling.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE and clear Busy, Done, RegWrite, Div_By_Zero, Result, Write_Reg and the counter to 0.
REQ-026 rst SHALL take priority over Start. A reset during RUN or DONE SHALL abort the operation with no RegWrite pulse.

Configuration
REQ-027 Macro MULDIV_DIV_EN defined: SHALL implement DIV ops per REQ-017..REQ-021.
REQ-028 Macro MULDIV_DIV_EN undefined: SHALL omit all divider logic. Op=1x SHALL go to DONE at E1 with Result=0, RegWrite=0, Done=1 and Div_By_Zero=0. MUL behaviour SHALL be unchanged.

Verification
REQ-029 A=0x1234, B=0x0010, Op=00, Dest_Reg=3 -> at E16 Done=1, Result=0x2340, Write_Reg=3, RegWrite=1. Repeat with Op=01 -> Result=0x0001.
REQ-030 A=0xFFFF, B=0xFFFF, Op=01 -> Result=0xFFFE. Op=00 -> Result=0x0001. Busy high E0..E17.
REQ-031 A=100, B=7, Op=10 -> Result=14. Op=11 -> Result=2. Div_By_Zero=0.
REQ-032 A=0x0055, B=0, Op=10 -> Done at E1, Result=0xFFFF, Div_By_Zero=1. Op=11 -> Result=0x0055.
REQ-033 Start MUL, pulse rst at E8 -> Busy=0 at E9, no RegWrite for 20 cycles. A second Start at E4 without reset -> ignored; Result matches the first operands.
REQ-034 MULDIV_DIV_EN undefined, A=100, B=7, Op=10 -> Done at E1, RegWrite=0, Result=0.
